// File: rtl/ov7670_capture_if.sv
// Bundle between the OV7670 capture stage and its neighbours: camera byte stream
// in, frame-buffer write port and frame status out.
interface ov7670_capture_if #(
  parameter int ADDR_W = 17
);
  logic              cam_vsync;
  logic              cam_href;
  logic [7:0]        cam_data;
  logic              we;
  logic [ADDR_W-1:0] waddr;
  logic [11:0]       wdata;
  logic              frame_done;
  logic              frame_short;

  modport master (
    input  cam_vsync, cam_href, cam_data,
    output we, waddr, wdata, frame_done, frame_short
  );

  modport slave (
    output cam_vsync, cam_href, cam_data,
    input  we, waddr, wdata, frame_done, frame_short
  );
endinterface

// File: rtl/ov7670_capture.sv
// OV7670 capture: pairs RGB565 bytes into RGB444 frame-buffer writes, PCLK domain.
// Define CAM_TEST_PATTERN_EN to replace pixel data with 8 vertical colour bars.
//
// state      | meaning
// WAIT_FRAME | after reset, waiting for a vsync rising edge
// ARMED      | in vertical blank, waiting for vsync to fall
// CAPTURE    | active frame, bytes paired and written
module ov7670_capture #(
  parameter int H_PIXELS = 320,
  parameter int V_LINES  = 240,
  parameter int ADDR_W   = 17
) (
  input  logic clk,
  input  logic reset,
  ov7670_capture_if.master bus
);
  localparam int COL_W  = $clog2(H_PIXELS + 1);
  localparam int LINE_W = $clog2(V_LINES + 1);
  localparam logic [COL_W-1:0]  COL_MAX   = COL_W'(H_PIXELS);
  localparam logic [LINE_W-1:0] LINE_MAX  = LINE_W'(V_LINES);
  localparam logic [ADDR_W-1:0] LINE_STEP = ADDR_W'(H_PIXELS);

  typedef enum logic [1:0] {WAIT_FRAME, ARMED, CAPTURE} state_t;
  state_t state, state_nxt;

  logic              vsync_r, href_r, vsync_d, href_d;
  logic [7:0]        data_r;
  logic              vsync_rise, vsync_fall, href_fall;
  logic              capture_start, frame_end, in_cap;
  logic              phase;
  logic [6:0]        b1_hi;
  logic [COL_W-1:0]  col;
  logic [LINE_W-1:0] line, line_upd;
  logic [ADDR_W-1:0] line_base, wr_ptr;
  logic              pair_done, col_step, pix_ok, line_end, line_clr;
  logic [11:0]       pixel;
  logic              we_q, frame_done_q, frame_short_q;
  logic [ADDR_W-1:0] waddr_q;
  logic [11:0]       wdata_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vsync_r <= 1'b0;
      href_r  <= 1'b0;
      data_r  <= '0;
      vsync_d <= 1'b0;
      href_d  <= 1'b0;
    end else begin
      vsync_r <= bus.cam_vsync;
      href_r  <= bus.cam_href;
      data_r  <= bus.cam_data;
      vsync_d <= vsync_r;
      href_d  <= href_r;
    end
  end

  assign vsync_rise = vsync_r & ~vsync_d;
  assign vsync_fall = ~vsync_r & vsync_d;
  assign href_fall  = ~href_r & href_d;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= WAIT_FRAME;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt     = state;
    capture_start = 1'b0;
    frame_end     = 1'b0;
    case (state)
      WAIT_FRAME: if (vsync_rise) state_nxt = ARMED;
      ARMED: begin
        if (vsync_fall) begin
          state_nxt     = CAPTURE;
          capture_start = 1'b1;
        end
      end
      CAPTURE: begin
        if (vsync_rise) begin
          state_nxt = ARMED;
          frame_end = 1'b1;
        end
      end
      default: state_nxt = WAIT_FRAME;
    endcase
  end

  assign in_cap    = (state == CAPTURE);
  assign pair_done = in_cap & href_r & phase;
  assign col_step  = pair_done & (col < COL_MAX);
  assign pix_ok    = (col < COL_MAX) && (line < LINE_MAX);
  assign line_end  = in_cap & href_fall & (col != '0);
  assign line_clr  = capture_start | line_end;
  // frame end sees the line count as if a coincident line end had already landed
  assign line_upd  = (line_end && (line < LINE_MAX)) ? line + LINE_W'(1) : line;

`ifdef CAM_TEST_PATTERN_EN
  localparam int ACC_W = $clog2(H_PIXELS + 8);
  localparam logic [ACC_W-1:0] ACC_H = ACC_W'(H_PIXELS);
  logic [ACC_W-1:0] bar_acc, acc_sum;
  logic [2:0]       bar_idx;

  // bar_idx tracks (col*8)/H_PIXELS, bar_acc the remainder
  assign acc_sum = bar_acc + ACC_W'(8);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bar_acc <= '0;
      bar_idx <= '0;
    end else if (line_clr) begin
      bar_acc <= '0;
      bar_idx <= '0;
    end else if (col_step) begin
      if (acc_sum >= ACC_H) begin
        bar_acc <= acc_sum - ACC_H;
        bar_idx <= bar_idx + 3'd1;
      end else begin
        bar_acc <= acc_sum;
      end
    end
  end

  always_comb begin
    pixel = 12'h000;
    case (bar_idx)
      3'd0: pixel = 12'hFFF;
      3'd1: pixel = 12'hFF0;
      3'd2: pixel = 12'h0FF;
      3'd3: pixel = 12'h0F0;
      3'd4: pixel = 12'hF0F;
      3'd5: pixel = 12'hF00;
      3'd6: pixel = 12'h00F;
      default: pixel = 12'h000;
    endcase
  end
`else
  assign pixel = {b1_hi[6:3], b1_hi[2:0], data_r[7], data_r[4:1]};
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      phase         <= 1'b0;
      b1_hi         <= '0;
      col           <= '0;
      line          <= '0;
      line_base     <= '0;
      wr_ptr        <= '0;
      we_q          <= 1'b0;
      waddr_q       <= '0;
      wdata_q       <= '0;
      frame_done_q  <= 1'b0;
      frame_short_q <= 1'b0;
    end else begin
      we_q         <= 1'b0;
      frame_done_q <= 1'b0;
      if (capture_start) begin
        phase     <= 1'b0;
        col       <= '0;
        line      <= '0;
        line_base <= '0;
        wr_ptr    <= '0;
        waddr_q   <= '0;
      end else if (in_cap) begin
        if (href_r) begin
          phase <= ~phase;
          if (!phase) b1_hi <= {data_r[7:4], data_r[2:0]};
          if (pair_done && pix_ok) begin
            we_q    <= 1'b1;
            waddr_q <= wr_ptr;
            wdata_q <= pixel;
            wr_ptr  <= wr_ptr + ADDR_W'(1);
          end
          if (col_step) col <= col + COL_W'(1);
        end else if (href_fall) begin
          phase <= 1'b0;
          if (line_end) begin
            col  <= '0;
            line <= line_upd;
            // stored lines restart at the next line base; dropped lines leave it alone
            if (line < LINE_MAX) begin
              line_base <= line_base + LINE_STEP;
              wr_ptr    <= line_base + LINE_STEP;
            end
          end
        end
        if (frame_end) begin
          frame_done_q  <= 1'b1;
          frame_short_q <= (line_upd < LINE_MAX);
        end
      end
    end
  end

  assign bus.we          = we_q;
  assign bus.waddr       = waddr_q;
  assign bus.wdata       = wdata_q;
  assign bus.frame_done  = frame_done_q;
  assign bus.frame_short = frame_short_q;
endmodule

// File: tb/tb_ov7670_capture.sv
// Randomised bench for ov7670_capture against a line/pixel reference model.
// Small frame geometry keeps full frames short; CAM_TEST_PATTERN_EN selects bar data.
module tb_ov7670_capture;
  localparam int H  = 48;
  localparam int V  = 16;
  localparam int AW = 10;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  ov7670_capture_if #(.ADDR_W(AW)) bus ();

  ov7670_capture #(.H_PIXELS(H), .V_LINES(V), .ADDR_W(AW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  typedef struct {
    int          cyc;
    int          addr;
    logic [11:0] data;
  } wr_t;

  typedef struct {
    int cyc;
    int short_f;
  } fd_t;

  wr_t wr_q[$];
  fd_t fd_q[$];
  wr_t wr_got;
  fd_t fd_got;

  logic [11:0] bar_col [8] = '{12'hFFF, 12'hFF0, 12'h0FF, 12'h0F0,
                               12'hF0F, 12'hF00, 12'h00F, 12'h000};

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_wr = 0;
  int n_fd = 0;
  int last_addr = -1;

  always @(negedge clk) begin
    if (!reset) begin
      if (bus.we) begin
        n_wr++;
        last_addr = int'(bus.waddr);
        if (wr_q.size() == 0) chk("we_extra", 32'd1, 32'd0);
        else begin
          wr_got = wr_q.pop_front();
          chk("we_cyc", cyc, wr_got.cyc);
          chk("waddr", 32'(bus.waddr), wr_got.addr);
          chk("wdata", 32'(bus.wdata), 32'(wr_got.data));
        end
      end
      if (bus.frame_done) begin
        n_fd++;
        if (fd_q.size() == 0) chk("fd_extra", 32'd1, 32'd0);
        else begin
          fd_got = fd_q.pop_front();
          chk("fd_cyc", cyc, fd_got.cyc);
          chk("fd_short", 32'(bus.frame_short), fd_got.short_f);
        end
      end
    end
  end

  // reference model: frame/line/pixel position as the camera protocol defines it
  int          m_line = 0, m_col = 0, m_half = 0, m_cap = 0, m_short = 0;
  logic [7:0]  m_b1 = '0;
  logic        hr_last = 1'b0;

  function automatic logic [11:0] exp_pix(input int col, input logic [7:0] b1, input logic [7:0] b2);
`ifdef CAM_TEST_PATTERN_EN
    return bar_col[(col * 8) / H] | (12'(b1 & b2) & 12'h000);
`else
    return {b1[7:4], b1[2:0], b2[7], b2[4:1]} | 12'(col & 0);
`endif
  endfunction

  task automatic drive(input logic vs, input logic hr, input logic [7:0] d);
    @(negedge clk);
    bus.cam_vsync = vs;
    bus.cam_href  = hr;
    bus.cam_data  = d;
    hr_last       = hr;
  endtask

  task automatic send_byte(input logic [7:0] d);
    wr_t w;
    drive(1'b0, 1'b1, d);
    if (m_cap != 0) begin
      if (m_half == 0) begin
        m_b1   = d;
        m_half = 1;
      end else begin
        m_half = 0;
        if (m_col < H && m_line < V) begin
          w.cyc  = cyc + 2;
          w.addr = m_line * H + m_col;
          w.data = exp_pix(m_col, m_b1, d);
          wr_q.push_back(w);
        end
        if (m_col < H) m_col++;
      end
    end
  endtask

  task automatic model_line_end();
    if (m_cap != 0) begin
      m_half = 0;
      if (m_col > 0) begin
        if (m_line < V) m_line++;
        m_col = 0;
      end
    end
  endtask

  task automatic send_line(input int n, input bit fixed, input int gap);
    for (int i = 0; i < n; i++) begin
      if (fixed) send_byte((i % 2 == 0) ? 8'hF8 : 8'h1F);
      else       send_byte(8'($urandom));
    end
    if (gap > 0) begin
      drive(1'b0, 1'b0, 8'($urandom));
      model_line_end();
      for (int g = 1; g < gap; g++) drive(1'b0, 1'b0, 8'($urandom));
    end
  endtask

  task automatic vs_rise(input int nhigh);
    fd_t f;
    logic was_href;
    was_href = hr_last;
    drive(1'b1, 1'b0, 8'($urandom));
    if (was_href) model_line_end();
    if (m_cap != 0) begin
      m_short   = (m_line < V) ? 1 : 0;
      f.cyc     = cyc + 2;
      f.short_f = m_short;
      fd_q.push_back(f);
      m_cap = 0;
    end
    for (int i = 1; i < nhigh; i++) drive(1'b1, 1'b0, 8'($urandom));
  endtask

  task automatic vs_fall();
    drive(1'b0, 1'b0, 8'($urandom));
    m_cap  = 1;
    m_line = 0;
    m_col  = 0;
    m_half = 0;
    repeat (2) drive(1'b0, 1'b0, 8'($urandom));
  endtask

  task automatic drain(input string tag);
    repeat (6) @(negedge clk);
    chk({tag, "_wr_left"}, wr_q.size(), 32'd0);
    chk({tag, "_fd_left"}, fd_q.size(), 32'd0);
  endtask

  task automatic check_idle_outputs(input string tag);
    chk({tag, "_we"}, 32'(bus.we), 32'd0);
    chk({tag, "_waddr"}, 32'(bus.waddr), 32'd0);
    chk({tag, "_wdata"}, 32'(bus.wdata), 32'd0);
    chk({tag, "_fd"}, 32'(bus.frame_done), 32'd0);
    chk({tag, "_fs"}, 32'(bus.frame_short), 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: no finish within time limit, got timeout expected finish");
    $fatal(1);
  end

  int n0, f0, nl;

  initial begin
    bus.cam_vsync = 1'b0;
    bus.cam_href  = 1'b0;
    bus.cam_data  = 8'h00;
    repeat (3) @(negedge clk);
    check_idle_outputs("rst");
    #1 reset = 1'b0;
    repeat (3) drive(1'b0, 1'b0, 8'($urandom));

    // first frame: one fixed-pattern line, then a full frame ending coincident with vsync
    vs_rise(10);
    vs_fall();
    n0 = n_wr;
    send_line(2 * H, 1'b1, 3);
    drain("s1");
    chk("s1_count", n_wr - n0, H);
    chk("s1_last", last_addr, H - 1);
    for (int l = 1; l < V; l++) send_line(2 * H, 1'b0, (l == V - 1) ? 0 : 2);
    f0 = n_fd;
    vs_rise(4);
    drain("s2");
    chk("s2_last", last_addr, H * V - 1);
    chk("s2_fd_count", n_fd - f0, 1);
    chk("s2_fs", 32'(bus.frame_short), 32'd0);

    // short frame with a single-byte href pulse that must not count as a line
    vs_fall();
    for (int l = 0; l < V / 2; l++)
      send_line((l == 2) ? 1 : $urandom_range(2 * H + 20, 2), 1'b0, $urandom_range(3, 1));
    vs_rise(5);
    drain("s3");
    chk("s3_fs", 32'(bus.frame_short), 32'd1);

    // odd-length overlong line, then a full frame with surplus lines
    vs_fall();
    n0 = n_wr;
    send_line(2 * H + 61, 1'b0, 2);
    drain("s4a");
    chk("s4_odd_count", n_wr - n0, H);
    send_line(2 * H, 1'b0, 2);
    for (int l = 2; l < V + 2; l++) send_line($urandom_range(2 * H + 20, 2), 1'b0, $urandom_range(3, 1));
    vs_rise(3);
    drain("s4");
    chk("s4_fs", 32'(bus.frame_short), 32'd0);

    // reset in the middle of a line; nothing written until vsync high->low
    vs_fall();
    for (int l = 0; l < 3; l++) send_line(2 * H, 1'b0, 2);
    send_line(20, 1'b0, 0);
    @(negedge clk);
    #1 reset = 1'b1;
    wr_q.delete();
    fd_q.delete();
    m_cap = 0;
    @(negedge clk);
    check_idle_outputs("mid_rst");
    #1 reset = 1'b0;
    n0 = n_wr;
    f0 = n_fd;
    send_line(40, 1'b0, 2);
    for (int l = 0; l < 3; l++) send_line(2 * H, 1'b0, 2);
    vs_rise(6);
    drain("s5a");
    chk("s5_no_wr", n_wr - n0, 0);
    chk("s5_no_fd", n_fd - f0, 0);
    vs_fall();
    send_line(2 * H, 1'b0, 2);
    drain("s5b");
    chk("s5_first_line_last", last_addr, H - 1);
    for (int l = 1; l < V; l++) send_line(2 * H, 1'b0, 2);
    vs_rise(4);
    drain("s5");
    chk("s5_fs", 32'(bus.frame_short), 32'd0);

    // random frames around the line limit
    for (int fr = 0; fr < 3; fr++) begin
      vs_fall();
      nl = $urandom_range(V + 2, V - 3);
      for (int l = 0; l < nl; l++)
        send_line($urandom_range(2 * H + 10, 0), 1'b0, (l == nl - 1) ? 0 : $urandom_range(3, 1));
      vs_rise($urandom_range(8, 2));
      drain("rnd");
      chk("rnd_fs", 32'(bus.frame_short), m_short);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
